mole_scorer: RTL and testbench
==============================

# mole_scorer

Score keeper for the whack-a-mole game: the producer side of the 24-bit `score` bus that the display driver consumes. It runs the game timer from the shared 1 ms pulse, judges each whack against the currently raised moles, and accumulates a saturating binary score with an optional streak multiplier. It keeps a high-score register and exposes game status to the mole generator and top level.

## Interface

- `NUM_MOLES`, 6: number of mole/button lanes.
- `GAME_SECONDS`, 30: game length in seconds, 1..255.
- `HIT_POINTS`, 10: base points per hit.
- `MISS_PENALTY`, 5: points removed per miss.
- `SCORE_MAX`, 99999: saturation ceiling, the largest value the 5-digit decimal display can show.

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `oneMsPulse` in 1: one-cycle pulse every 1 ms.
- `start` in 1: one-cycle start request.
- `moleActive` in NUM_MOLES: raised-mole mask from the mole generator.
- `whack` in NUM_MOLES: debounced one-cycle button pulses.
- `score` out 24: current score, binary.
- `highScore` out 24: best completed-game score.
- `timeLeft` out 8: seconds remaining.
- `gameActive` out 1: high while in PLAY.
- `gameOver` out 1: one-cycle pulse at end of game.
- `hitPulse`, `missPulse` out 1: one-cycle event strobes.

## Operation

- States are IDLE, PLAY and OVER. Reset enters IDLE.
- **Reset values:**
  - `score`, `highScore`, `timeLeft`, the streak count and the ms counter are all 0.
  - All 1-bit outputs are 0.
- **IDLE:**
  - `score` holds the last game's value.
  - On `start`: go to PLAY, set `score` to 0, set `timeLeft` to GAME_SECONDS, set the ms counter and streak to 0.
- **PLAY:**
  - Each `oneMsPulse` increments the ms counter (0..999).
  - When the counter is at 999 and a pulse arrives, the counter wraps to 0 and `timeLeft` decrements.
  - The decrement that takes `timeLeft` from 1 to 0 also moves the FSM to OVER.
  - `start` is ignored in PLAY.
- **Whack judging** (PLAY only, including the cycle that moves to OVER):
  - A hit is a cycle where `whack & moleActive` is nonzero. It is counted once per cycle, regardless of how many bits are set.
  - A miss is a cycle where `whack & ~moleActive` is nonzero and there is no hit. A hit takes precedence over a miss.
- **Hit:**
  - Add `HIT_POINTS*mult` to the score.
  - Compute the sum 25 bits wide and clamp it to SCORE_MAX.
  - Increment the streak, saturating at 15.
- **Miss:**
  - Subtract MISS_PENALTY from the score, floored at 0.
  - Clear the streak.
- **OVER** (one cycle):
  - Pulse `gameOver`.
  - If `score > highScore`, load `highScore` with `score`.
  - Return to IDLE.
- Whacks in IDLE or OVER produce no events and no score change.
- `reset` during any state aborts the game and clears `highScore`.

## Timing

- All outputs are registered.
- `score`, `hitPulse` and `missPulse` are valid in the cycle after the `whack` cycle (latency 1).
- `timeLeft` updates in the cycle after the qualifying `oneMsPulse`.
- `gameActive` drops in the same cycle that `gameOver` is high.
- `highScore` updates in the cycle after `gameOver`.
- `start` in the same cycle as `reset` is ignored.
- `start` arriving in the OVER cycle is ignored. It is accepted from IDLE on the next cycle.
- `gameActive` rises in the cycle after `start` is accepted.

## Configuration

- `MOLE_SCORER_COMBO_EN` defined:
  - `mult = 1 + streak/4`, capped at 4 (streak 0–3 gives 1, 4–7 gives 2, 8–11 gives 3, 12 or more gives 4).
- Undefined:
  - `mult` is fixed at 1.
  - The streak register is not built.
  - All other behaviour is identical.

## Structure

- `mole_pkg` holds:
  - the state enum (IDLE, PLAY, OVER);
  - `SCORE_W = 24`;
  - `MULT_MAX = 4`;
  - `STREAK_MAX = 15`.
- One sub-module, `sec_countdown`:
  - ms counter plus `timeLeft` down-counter;
  - load and enable inputs;
  - emits a `done` strobe on the 1→0 transition.
- Scoring arithmetic, judging and the FSM stay in `mole_scorer`.

## Test plan

- **Reset / start:** `reset`, then `start` → `score`=0, `timeLeft`=30, `gameActive`=1 one cycle later.
- **Hit:** `moleActive`=6'b000100, `whack`=6'b000100 → `hitPulse`, and `score` 0→10. Then `whack`=6'b000001 → `missPulse`, `score` 5. Then 2 more misses → `score` 0, no underflow.
- **Simultaneous hit and miss:** `whack`=6'b000101 with `moleActive`=6'b000100 → counted as a hit only, `score` +10.
- **Combo:** with the macro, 5 consecutive hits → `score` 10,20,30,40,60. Without the macro → 10,20,30,40,50.
- **Saturation:** force `score` to 99995 via repeated hits (HIT_POINTS=10 bench override), then hit → `score`=99999.
- **Timeout:** 30 000 `oneMsPulse` → `timeLeft` reaches 0, one-cycle `gameOver`, `highScore` takes the score. A second, lower game leaves `highScore` unchanged. `reset` mid-PLAY → all outputs 0.

Source files
------------

// File: rtl/mole_pkg.sv
// rtl/mole_pkg.sv - shared types and constants for the whack-a-mole score keeper
// Contents: game state enum, score bus width, combo multiplier and streak ceilings.
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int SCORE_W    = 24;
  localparam int MULT_MAX   = 4;
  localparam int STREAK_MAX = 15;

endpackage

// File: rtl/mole_scorer_if.sv
// rtl/mole_scorer_if.sv - game I/O bundle between the game top level and mole_scorer
// master: drives oneMsPulse, start, moleActive, whack; observes score/status.
// slave : the score keeper; consumes the inputs and drives score, highScore,
//         timeLeft, gameActive, gameOver, hitPulse, missPulse.
interface mole_scorer_if #(
  parameter int NUM_MOLES = 6
);
  import mole_pkg::*;

  logic                 oneMsPulse;
  logic                 start;
  logic [NUM_MOLES-1:0] moleActive;
  logic [NUM_MOLES-1:0] whack;
  logic [SCORE_W-1:0]   score;
  logic [SCORE_W-1:0]   highScore;
  logic [7:0]           timeLeft;
  logic                 gameActive;
  logic                 gameOver;
  logic                 hitPulse;
  logic                 missPulse;

  modport master (
    output oneMsPulse, start, moleActive, whack,
    input  score, highScore, timeLeft, gameActive, gameOver, hitPulse, missPulse
  );

  modport slave (
    input  oneMsPulse, start, moleActive, whack,
    output score, highScore, timeLeft, gameActive, gameOver, hitPulse, missPulse
  );

endinterface

// File: rtl/sec_countdown.sv
// rtl/sec_countdown.sv - game timer: 0..999 ms counter feeding a seconds down-counter
// Ports: clk, reset (sync, active high), load_i (restart at GAME_SECONDS),
//        en_i (one 1 ms tick), time_left_o (seconds remaining),
//        done_o (combinational strobe on the tick that takes time_left 1 -> 0).
module sec_countdown #(
  parameter int GAME_SECONDS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic       en_i,
  output logic [7:0] time_left_o,
  output logic       done_o
);

  logic [9:0] ms_q, ms_d;
  logic [7:0] sec_q, sec_d;
  logic       wrap;

  assign wrap = en_i && (ms_q == 10'd999);

  always_comb begin
    ms_d  = ms_q;
    sec_d = sec_q;
    if (load_i) begin
      ms_d  = '0;
      sec_d = 8'(GAME_SECONDS);
    end else if (en_i && (sec_q != 8'd0)) begin
      if (wrap) begin
        ms_d  = '0;
        sec_d = sec_q - 8'd1;
      end else begin
        ms_d = ms_q + 10'd1;
      end
    end
  end

  // Combinational so the FSM leaves PLAY on the same edge the counter reaches 0.
  assign done_o      = !load_i && wrap && (sec_q == 8'd1);
  assign time_left_o = sec_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_q  <= '0;
      sec_q <= '0;
    end else begin
      ms_q  <= ms_d;
      sec_q <= sec_d;
    end
  end

endmodule

// File: rtl/mole_scorer.sv
// rtl/mole_scorer.sv - whack-a-mole score keeper: game FSM, hit/miss judging, saturating score, high score
// Ports: clk, reset (sync, active high), bus (mole_scorer_if.slave: timer pulse,
//        start, mole/whack masks in; score, highScore, timeLeft and status out).
// Build option: MOLE_SCORER_COMBO_EN adds the streak register and the
//        1 + streak/4 hit multiplier; without it every hit scores HIT_POINTS.
module mole_scorer
  import mole_pkg::*;
#(
  parameter int NUM_MOLES    = 6,
  parameter int GAME_SECONDS = 30,
  parameter int HIT_POINTS   = 10,
  parameter int MISS_PENALTY = 5,
  parameter int SCORE_MAX    = 99999
) (
  input logic          clk,
  input logic          reset,
  mole_scorer_if.slave bus
);

  state_t               state_q, state_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W-1:0]   high_q, high_d;
  logic                 hit_q, miss_q;
  logic [NUM_MOLES-1:0] hit_mask, miss_mask;
  logic                 play, start_game, hit, miss, done;
  logic [2:0]           mult;
  logic [SCORE_W:0]     hit_sum;
  logic [SCORE_W-1:0]   hit_score, miss_score;

  assign play       = (state_q == PLAY);
  assign start_game = (state_q == IDLE) && bus.start;
  assign hit_mask   = bus.whack & bus.moleActive;
  assign miss_mask  = bus.whack & ~bus.moleActive;
  assign hit        = play && (|hit_mask);
  assign miss       = play && (|miss_mask) && !hit;

  sec_countdown #(
    .GAME_SECONDS(GAME_SECONDS)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (start_game),
    .en_i       (play && bus.oneMsPulse),
    .time_left_o(bus.timeLeft),
    .done_o     (done)
  );

`ifdef MOLE_SCORER_COMBO_EN
  logic [3:0] streak_q, streak_d;
  logic [2:0] mult_raw;

  assign mult_raw = 3'(streak_q[3:2]) + 3'd1;
  assign mult     = (mult_raw > 3'(MULT_MAX)) ? 3'(MULT_MAX) : mult_raw;

  always_comb begin
    streak_d = streak_q;
    if (start_game) begin
      streak_d = '0;
    end else if (hit) begin
      if (streak_q != 4'(STREAK_MAX)) streak_d = streak_q + 4'd1;
    end else if (miss) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) streak_q <= '0;
    else       streak_q <= streak_d;
  end
`else
  assign mult = 3'd1;
`endif

  // One extra bit so the clamp sees any carry past the 24-bit bus.
  assign hit_sum    = {1'b0, score_q} + 25'(HIT_POINTS) * 25'(mult);
  assign hit_score  = (hit_sum > 25'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : hit_sum[SCORE_W-1:0];
  assign miss_score = (score_q < SCORE_W'(MISS_PENALTY)) ? '0 : score_q - SCORE_W'(MISS_PENALTY);

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = PLAY;
      PLAY:    if (done) state_d = OVER;
      OVER:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, decoded straight from the state register
  always_comb begin
    bus.gameActive = (state_q == PLAY);
    bus.gameOver   = (state_q == OVER);
  end

  always_comb begin
    score_d = score_q;
    if (start_game)  score_d = '0;
    else if (hit)    score_d = hit_score;
    else if (miss)   score_d = miss_score;
  end

  always_comb begin
    high_d = high_q;
    if ((state_q == OVER) && (score_q > high_q)) high_d = score_q;
  end

  // FSM and datapath state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      score_q <= '0;
      high_q  <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      high_q  <= high_d;
      hit_q   <= hit;
      miss_q  <= miss;
    end
  end

  assign bus.score     = score_q;
  assign bus.highScore = high_q;
  assign bus.hitPulse  = hit_q;
  assign bus.missPulse = miss_q;

endmodule

// File: tb/tb_mole_scorer.sv
// tb/tb_mole_scorer.sv - self-checking bench for mole_scorer against a behavioural game model
module tb_mole_scorer;

`ifdef MOLE_SCORER_COMBO_EN
  localparam bit COMBO = 1'b1;
`else
  localparam bit COMBO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mole_scorer_if #(.NUM_MOLES(6)) bus ();

  mole_scorer #(
    .NUM_MOLES   (6),
    .GAME_SECONDS(30),
    .HIT_POINTS  (10),
    .MISS_PENALTY(5),
    .SCORE_MAX   (99999)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // model: 0 idle, 1 playing, 2 game just ended
  int m_phase, m_score, m_high, m_time, m_ms, m_streak;
  bit m_hit, m_miss;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int points_for_hit(input int streak);
    int m;
    m = 1 + streak / 4;
    if (m > 4) m = 4;
    return COMBO ? 10 * m : 10;
  endfunction

  task automatic model_step(input bit rst, input bit st, input bit pl,
                            input logic [5:0] ma, input logic [5:0] wh);
    bit h, ms;
    if (rst) begin
      m_phase = 0; m_score = 0; m_high = 0; m_time = 0; m_ms = 0; m_streak = 0;
      m_hit = 0; m_miss = 0;
      return;
    end
    m_hit  = 0;
    m_miss = 0;
    if (m_phase == 0) begin
      if (st) begin
        m_phase = 1; m_score = 0; m_time = 30; m_ms = 0; m_streak = 0;
      end
    end else if (m_phase == 1) begin
      h  = (wh & ma) != 0;
      ms = ((wh & ~ma) != 0) && !h;
      if (h) begin
        m_score = m_score + points_for_hit(m_streak);
        if (m_score > 99999) m_score = 99999;
        if (m_streak < 15) m_streak++;
        m_hit = 1;
      end else if (ms) begin
        m_score = (m_score < 5) ? 0 : m_score - 5;
        m_streak = 0;
        m_miss = 1;
      end
      if (pl) begin
        if (m_ms == 999) begin
          m_ms = 0;
          m_time--;
          if (m_time == 0) m_phase = 2;
        end else begin
          m_ms++;
        end
      end
    end else begin
      if (m_score > m_high) m_high = m_score;
      m_phase = 0;
    end
  endtask

  task automatic tick(input bit rst, input bit st, input bit pl,
                      input logic [5:0] ma, input logic [5:0] wh);
    reset          = rst;
    bus.start      = st;
    bus.oneMsPulse = pl;
    bus.moleActive = ma;
    bus.whack      = wh;
    model_step(rst, st, pl, ma, wh);
    @(posedge clk);
    #1;
    check("score",      bus.score,      m_score);
    check("highScore",  bus.highScore,  m_high);
    check("timeLeft",   bus.timeLeft,   m_time);
    check("gameActive", bus.gameActive, (m_phase == 1));
    check("gameOver",   bus.gameOver,   (m_phase == 2));
    check("hitPulse",   bus.hitPulse,   m_hit);
    check("missPulse",  bus.missPulse,  m_miss);
  endtask

  localparam logic [5:0] MOLE = 6'b000100;
  localparam logic [5:0] HITW = 6'b000100;
  localparam logic [5:0] MISW = 6'b000001;

  int combo_exp[5];

  initial begin
    reset = 1'b1; bus.start = 1'b0; bus.oneMsPulse = 1'b0;
    bus.moleActive = '0; bus.whack = '0;
    m_phase = 0; m_score = 0; m_high = 0; m_time = 0; m_ms = 0; m_streak = 0;
    m_hit = 0; m_miss = 0;

    // reset, with a start request that must be ignored
    tick(1, 0, 0, '0, '0);
    tick(1, 1, 0, 6'h3f, 6'h3f);
    check("reset_score", bus.score, 0);
    check("reset_active", bus.gameActive, 0);
    tick(0, 0, 0, 6'h3f, 6'h3f);
    check("idle_no_hit", bus.hitPulse, 0);

    // start
    tick(0, 1, 0, '0, '0);
    check("start_timeLeft", bus.timeLeft, 30);
    check("start_active", bus.gameActive, 1);
    check("start_score", bus.score, 0);

    // hit, miss, floor at zero
    tick(0, 0, 0, MOLE, HITW);
    check("hit_score", bus.score, 10);
    check("hit_pulse", bus.hitPulse, 1);
    tick(0, 0, 0, MOLE, MISW);
    check("miss_score", bus.score, 5);
    check("miss_pulse", bus.missPulse, 1);
    tick(0, 0, 0, MOLE, MISW);
    tick(0, 0, 0, MOLE, MISW);
    check("miss_floor", bus.score, 0);

    // hit and miss in one cycle count as a hit only
    tick(0, 0, 0, MOLE, 6'b000101);
    check("both_score", bus.score, 10);
    check("both_no_miss", bus.missPulse, 0);

    // five consecutive hits from zero with a cleared streak
    tick(0, 0, 0, MOLE, MISW);
    tick(0, 0, 0, MOLE, MISW);
    if (COMBO) combo_exp = '{10, 20, 30, 40, 60};
    else       combo_exp = '{10, 20, 30, 40, 50};
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, MOLE, HITW);
      check("combo_run", bus.score, combo_exp[i]);
    end

    // random play
    for (int i = 0; i < 2000; i++) begin
      logic [5:0] ma, wh;
      ma = 6'($urandom);
      wh = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      tick(0, ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, ma, wh);
    end

    // saturation: climb, step down to ...5, then land on 99995 with unit-multiplier hits
    for (int i = 0; i < 20000 && m_score < 99960; i++) tick(0, 0, 0, MOLE, HITW);
    for (int i = 0; i < 20 && !((m_score % 10 == 5) && (m_score <= 99975)); i++)
      tick(0, 0, 0, MOLE, MISW);
    for (int i = 0; i < 10 && m_score < 99995; i++) tick(0, 0, 0, MOLE, HITW);
    check("sat_reach_99995", bus.score, 99995);
    tick(0, 0, 0, MOLE, HITW);
    check("sat_clamp", bus.score, 99999);
    tick(0, 0, 0, MOLE, HITW);
    check("sat_hold", bus.score, 99999);

    // run the clock out
    for (int i = 0; i < 40000 && m_phase == 1; i++) tick(0, 0, 1, '0, '0);
    check("g1_gameOver", bus.gameOver, 1);
    check("g1_timeLeft", bus.timeLeft, 0);
    check("g1_active_low", bus.gameActive, 0);
    tick(0, 1, 0, MOLE, HITW);  // start in the OVER cycle is ignored
    check("over_start_ignored", bus.gameActive, 0);
    check("g1_highScore", bus.highScore, 99999);
    tick(0, 0, 0, '0, '0);
    check("g1_idle_hold", bus.score, 99999);

    // second, lower game
    tick(0, 1, 0, '0, '0);
    tick(0, 0, 1, MOLE, HITW);
    tick(0, 0, 1, MOLE, HITW);
    check("g2_score", bus.score, 20);
    for (int i = 0; i < 40000 && m_phase == 1; i++) tick(0, 0, 1, '0, '0);
    check("g2_gameOver", bus.gameOver, 1);
    tick(0, 0, 0, '0, '0);
    check("g2_high_kept", bus.highScore, 99999);
    check("g2_score_hold", bus.score, 20);

    // reset mid-game
    tick(0, 1, 0, '0, '0);
    tick(0, 0, 1, MOLE, HITW);
    for (int i = 0; i < 50; i++) tick(0, 0, 1, '0, '0);
    tick(1, 0, 0, MOLE, HITW);
    check("rst_mid_score", bus.score, 0);
    check("rst_mid_high", bus.highScore, 0);
    check("rst_mid_time", bus.timeLeft, 0);
    check("rst_mid_active", bus.gameActive, 0);
    check("rst_mid_hit", bus.hitPulse, 0);
    tick(0, 0, 0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
